// File: rtl/vj_pkg.sv
// Shared Viola-Jones constants: pyramid scale table, full-frame geometry and
// the detection record carried between the upscaler and the result buffer.
package vj_pkg;

  localparam int PYRAMID_LEVELS = 5;
  localparam int LAPTOP_WIDTH   = 640;
  localparam int LAPTOP_HEIGHT  = 480;

  // Q16.16 factors; level 0 is the smallest image, the last level is 1.0.
  localparam logic [31:0] PYRAMID_SCALES [PYRAMID_LEVELS] = '{
    32'h0002_8000,
    32'h0002_0000,
    32'h0001_8000,
    32'h0001_4000,
    32'h0001_0000
  };

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] size;
  } det_t;

  function automatic logic [31:0] pyramid_scale(input int unsigned level);
    pyramid_scale = 32'h0;
    for (int unsigned i = 0; i < PYRAMID_LEVELS; i++) begin
      if (level == i) pyramid_scale = PYRAMID_SCALES[i];
    end
  endfunction

endpackage

// File: rtl/det_fifo.sv
// Synchronous first-word-fall-through FIFO of det_t records with occupancy
// count; head reads as all-zero while empty.
module det_fifo
  import vj_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  det_t        push_data,
  input  logic        pop,
  output det_t        head,
  output logic [AW:0] count
);

  det_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/detection_upscaler.sv
// Maps (level, x, y) window hits from a pyramid level back to full-frame
// coordinates through a two-stage pipeline feeding a credit-managed FIFO.
module detection_upscaler
  import vj_pkg::*;
#(
  parameter int LEVELS     = PYRAMID_LEVELS,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN        = 24,
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          det_valid,
  output logic          det_ready,
  input  logic [LW-1:0] det_level,
  input  logic [31:0]   det_x,
  input  logic [31:0]   det_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_x,
  output logic [31:0]   out_y,
  output logic [31:0]   out_size,
  output logic [15:0]   err_count
);

  logic          level_ok;
  logic [31:0]   scale;
  logic [47:0]   prod_x, prod_y, prod_s;

  logic          s1_valid, s1_ok;
  logic [47:0]   s1_px, s1_py, s1_ps;

  logic [31:0]   x_s, y_s, size_s, size_c;
  det_t          s2_next;

  logic          s2_valid, s2_ok;
  det_t          s2_entry;

  det_t          head;
  logic [CW-1:0] fifo_count;
  logic [31:0]   in_flight;

  always_comb begin
    level_ok = 32'(det_level) < 32'(LEVELS);
    scale    = pyramid_scale(32'(det_level));
    prod_x   = 48'(det_x) * 48'(scale);
    prod_y   = 48'(det_y) * 48'(scale);
    prod_s   = 48'(WIN)   * 48'(scale);
  end

  // Size is clamped first so the corner limits below can never underflow.
  always_comb begin
    x_s          = 32'(s1_px >> 16);
    y_s          = 32'(s1_py >> 16);
    size_s       = 32'(s1_ps >> 16);
    size_c       = (size_s > 32'(LAPTOP_HEIGHT)) ? 32'(LAPTOP_HEIGHT) : size_s;
    s2_next.size = size_c;
    s2_next.x    = (x_s > 32'(LAPTOP_WIDTH) - size_c) ? 32'(LAPTOP_WIDTH) - size_c : x_s;
    s2_next.y    = (y_s > 32'(LAPTOP_HEIGHT) - size_c) ? 32'(LAPTOP_HEIGHT) - size_c : y_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ok    <= 1'b0;
      s1_px    <= '0;
      s1_py    <= '0;
      s1_ps    <= '0;
      s2_valid <= 1'b0;
      s2_ok    <= 1'b0;
      s2_entry <= '0;
    end else begin
      s1_valid <= det_valid && det_ready;
      s1_ok    <= level_ok;
      s1_px    <= prod_x;
      s1_py    <= prod_y;
      s1_ps    <= prod_s;
      s2_valid <= s1_valid;
      s2_ok    <= s1_ok;
      s2_entry <= s2_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (s2_valid && !s2_ok && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

  // Every in-flight entry holds a FIFO credit, so S2 can always push.
  assign in_flight = 32'(fifo_count) + 32'(s1_valid) + 32'(s2_valid);
  assign det_ready = in_flight < 32'(FIFO_DEPTH);
  assign out_valid = (fifo_count != '0);

  det_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (s2_valid && s2_ok),
    .push_data (s2_entry),
    .pop       (out_valid && out_ready),
    .head      (head),
    .count     (fifo_count)
  );

  assign out_x    = head.x;
  assign out_y    = head.y;
  assign out_size = head.size;

endmodule

// File: tb/tb_detection_upscaler.sv
// Directed self-checking bench for detection_upscaler with the default
// five-level scale table (2.5, 2.0, 1.5, 1.25, 1.0) and a 640x480 frame.
module tb_detection_upscaler;
  import vj_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        det_valid = 1'b0;
  logic        det_ready;
  logic [2:0]  det_level = '0;
  logic [31:0] det_x = '0;
  logic [31:0] det_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_x, out_y, out_size;
  logic [15:0] err_count;

  int compared   = 0;
  int mismatched = 0;

  detection_upscaler #(
    .LEVELS     (5),
    .FIFO_DEPTH (4),
    .WIN        (24)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .det_valid (det_valid),
    .det_ready (det_ready),
    .det_level (det_level),
    .det_x     (det_x),
    .det_y     (det_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_size  (out_size),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    det_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    compared++;
    if (det_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_det_ready: got %b want 1", det_ready);
    end
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    compared++;
    if ({out_x, out_y, out_size} !== 96'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got x=%0d y=%0d size=%0d want all 0", out_x, out_y, out_size);
    end
    compared++;
    if (err_count !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_scaling();
    int lv [3] = '{4, 3, 0};
    int xv [3] = '{10, 100, 4};
    int yv [3] = '{20, 40, 8};
    int ex [3] = '{10, 125, 10};
    int ey [3] = '{20, 50, 20};
    int es [3] = '{24, 30, 60};
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      det_valid = 1'b1;
      det_level = 3'(lv[v]);
      det_x     = 32'(xv[v]);
      det_y     = 32'(yv[v]);
      compared++;
      if (det_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL scale%0d_ready: got %b want 1", v, det_ready);
      end
      tick();
      det_valid = 1'b0;
      tick();
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL scale%0d_early: out_valid got %b want 0 after one edge", v, out_valid);
      end
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_x !== 32'(ex[v]) || out_y !== 32'(ey[v]) || out_size !== 32'(es[v])) begin
        mismatched++;
        $display("[TB] FAIL scale%0d_result: got v=%b x=%0d y=%0d size=%0d want v=1 x=%0d y=%0d size=%0d",
                 v, out_valid, out_x, out_y, out_size, ex[v], ey[v], es[v]);
      end
      compared++;
      if (err_count !== 16'd0) begin
        mismatched++;
        $display("[TB] FAIL scale%0d_err: got %0d want 0", v, err_count);
      end
      tick();
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL scale%0d_pop: out_valid got %b want 0", v, out_valid);
      end
    end
  endtask

  task automatic test_clamp();
    out_ready = 1'b1;
    det_valid = 1'b1;
    det_level = 3'd1;
    det_x     = 32'(LAPTOP_WIDTH - 10);
    det_y     = 32'd470;
    tick();
    det_valid = 1'b0;
    tick();
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_size !== 32'd48) begin
      mismatched++;
      $display("[TB] FAIL clamp_size: got v=%b size=%0d want v=1 size=48", out_valid, out_size);
    end
    compared++;
    if (out_x !== 32'(LAPTOP_WIDTH - 48)) begin
      mismatched++;
      $display("[TB] FAIL clamp_x: got %0d want %0d", out_x, LAPTOP_WIDTH - 48);
    end
    compared++;
    if (out_y !== 32'(LAPTOP_HEIGHT - 48)) begin
      mismatched++;
      $display("[TB] FAIL clamp_y: got %0d want %0d", out_y, LAPTOP_HEIGHT - 48);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int   idx = 0;
    int   popped = 0;
    int   cyc = 0;
    int   got [8];
    logic rdy, dv, pv;
    logic [31:0] px;
    for (int i = 0; i < 8; i++) got[i] = -1;
    out_ready = 1'b0;
    det_level = 3'd4;
    det_y     = 32'd0;
    for (int c = 0; c < 8; c++) begin
      det_valid = 1'b1;
      det_x     = 32'(idx);
      rdy       = det_ready;
      tick();
      if (rdy) idx++;
    end
    compared++;
    if (idx !== 4) begin
      mismatched++;
      $display("[TB] FAIL bp_accepted: got %0d want 4", idx);
    end
    compared++;
    if (det_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_full_ready: got %b want 0", det_ready);
    end
    compared++;
    if (out_valid !== 1'b1 || out_x !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL bp_head: got v=%b x=%0d want v=1 x=0", out_valid, out_x);
    end
    out_ready = 1'b1;
    while (popped < 8 && cyc < 40) begin
      dv        = (idx < 8);
      det_valid = dv;
      det_x     = 32'(idx);
      rdy       = det_ready;
      pv        = out_valid;
      px        = out_x;
      tick();
      cyc++;
      if (rdy && dv) idx++;
      if (pv) begin
        if (popped < 8) got[popped] = int'(px);
        popped++;
      end
    end
    det_valid = 1'b0;
    compared++;
    if (popped !== 8) begin
      mismatched++;
      $display("[TB] FAIL bp_popped: got %0d want 8 within 40 cycles", popped);
    end
    compared++;
    if (cyc !== 8) begin
      mismatched++;
      $display("[TB] FAIL bp_cadence: drain took %0d cycles want 8", cyc);
    end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (got[i] !== i) begin
        mismatched++;
        $display("[TB] FAIL bp_order%0d: got %0d want %0d", i, got[i], i);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_invalid_level();
    int   lv [3] = '{4, 5, 4};
    int   xv [3] = '{1, 99, 2};
    int   got [2] = '{-1, -1};
    int   popped = 0;
    logic pv;
    logic [31:0] px;
    out_ready = 1'b1;
    det_y     = 32'd0;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        det_valid = 1'b1;
        det_level = 3'(lv[c]);
        det_x     = 32'(xv[c]);
      end else begin
        det_valid = 1'b0;
      end
      pv = out_valid;
      px = out_x;
      tick();
      if (pv) begin
        if (popped < 2) got[popped] = int'(px);
        popped++;
      end
      if (c == 2) begin
        compared++;
        if (err_count !== 16'd0) begin
          mismatched++;
          $display("[TB] FAIL inv_err_before: got %0d want 0", err_count);
        end
      end
      if (c == 3) begin
        compared++;
        if (err_count !== 16'd1) begin
          mismatched++;
          $display("[TB] FAIL inv_err_at_n2: got %0d want 1", err_count);
        end
      end
    end
    compared++;
    if (popped !== 2) begin
      mismatched++;
      $display("[TB] FAIL inv_count: got %0d outputs want 2", popped);
    end
    compared++;
    if (got[0] !== 1 || got[1] !== 2) begin
      mismatched++;
      $display("[TB] FAIL inv_order: got %0d,%0d want 1,2", got[0], got[1]);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    det_level = 3'd4;
    det_y     = 32'd0;
    for (int c = 0; c < 3; c++) begin
      det_valid = 1'b1;
      det_x     = 32'(10 + c);
      tick();
    end
    det_valid = 1'b0;
    tick();
    tick();
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_x !== 32'd10) begin
      mismatched++;
      $display("[TB] FAIL mid_buffered: got v=%b x=%0d want v=1 x=10", out_valid, out_x);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || out_x !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_out_cleared: got v=%b x=%0d want v=0 x=0", out_valid, out_x);
    end
    compared++;
    if (err_count !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_err_cleared: got %0d want 0", err_count);
    end
    compared++;
    if (det_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mid_ready: got %b want 1", det_ready);
    end
    out_ready = 1'b1;
    det_valid = 1'b1;
    det_x     = 32'd33;
    det_y     = 32'd44;
    tick();
    det_valid = 1'b0;
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_stale: out_valid got %b want 0", out_valid);
    end
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_x !== 32'd33 || out_y !== 32'd44 || out_size !== 32'd24) begin
      mismatched++;
      $display("[TB] FAIL mid_after: got v=%b x=%0d y=%0d size=%0d want v=1 x=33 y=44 size=24",
               out_valid, out_x, out_y, out_size);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_scaling();
    test_clamp();
    test_backpressure();
    test_invalid_level();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
